// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches words from a synchronous-read instruction memory, issues them
// one at a time on the cpu instruction bus, and stalls on tensor-core operates with a timeout.
module instruction_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH:0]   program_length_in,
    output logic                  imem_read_enable_out,
    output logic [ADDR_WIDTH-1:0] imem_read_address_out,
    input  logic [31:0]           imem_read_data_in,
    input  logic                  tensor_core_done_in,
    output logic [31:0]           current_instruction_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  timeout_error_out,
    output logic [15:0]           issued_count_out
);
    localparam logic [7:0]  OP_NOP     = 8'h08;
    localparam logic [7:0]  OP_OPERATE = 8'h05;
    localparam logic [7:0]  OP_HALT    = 8'hFF;
    localparam logic [31:0] NOP_WORD   = {24'h00_0000, OP_NOP};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_TC = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // One spare bit so the wait counter can step past its last value without wrapping.
    localparam int                    WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = (ADDR_WIDTH + 1)'(0);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH:0]   r_len;
    logic [WAIT_W-1:0]     r_wait_count;
    logic                  r_imem_en;
    logic [31:0]           r_instr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           r_count;

    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic [7:0]            w_opcode;
    logic                  w_last;
    logic                  w_start_ok;
    logic                  w_issue_valid;
    logic                  w_timeout;

    assign w_opcode      = imem_read_data_in[7:0];
    assign w_last        = ({1'b0, r_pc} == (r_len - LEN_ONE));
    assign w_start_ok    = (r_state == S_IDLE) && start_in;
    assign w_issue_valid = (r_state == S_ISSUE) && (w_opcode != OP_HALT);
    assign w_timeout     = (r_state == S_WAIT_TC) && !tensor_core_done_in &&
                           (r_wait_count == WAIT_LAST);

    // Next-state and program-counter selection.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_next_pc = {ADDR_WIDTH{1'b0}};
                    if (program_length_in == LEN_ZERO) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: w_next_state = S_ISSUE;
            S_ISSUE: begin
                if (w_opcode == OP_HALT) begin
                    w_next_state = S_DONE;
                end else if (w_opcode == OP_OPERATE) begin
                    w_next_state = S_WAIT_TC;
                end else if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_pc    = r_pc + PC_ONE;
                    w_next_state = S_FETCH;
                end
            end
            S_WAIT_TC: begin
                if (tensor_core_done_in) begin
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_pc    = r_pc + PC_ONE;
                        w_next_state = S_FETCH;
                    end
                end else if (r_wait_count == WAIT_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT_TC;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, counters and registered outputs; the issued word and done pulse trail their state by one cycle.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state      <= S_IDLE;
            r_pc         <= {ADDR_WIDTH{1'b0}};
            r_len        <= LEN_ZERO;
            r_wait_count <= {WAIT_W{1'b0}};
            r_imem_en    <= 1'b0;
            r_instr      <= NOP_WORD;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_count      <= 16'h0000;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_imem_en    <= (w_next_state == S_FETCH);
            r_busy       <= (w_next_state == S_FETCH) || (w_next_state == S_ISSUE) ||
                            (w_next_state == S_WAIT_TC);
            r_done       <= (r_state == S_DONE);
            r_instr      <= w_issue_valid ? imem_read_data_in : NOP_WORD;
            r_wait_count <= (r_state == S_WAIT_TC) ? (r_wait_count + WAIT_ONE) : {WAIT_W{1'b0}};
            if (w_start_ok) begin
                r_len   <= program_length_in;
                r_count <= 16'h0000;
                r_err   <= 1'b0;
            end else begin
                if (w_issue_valid && (r_count != 16'hFFFF)) begin
                    r_count <= r_count + 16'h0001;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign imem_read_enable_out    = r_imem_en;
    assign imem_read_address_out   = r_pc;
    assign current_instruction_out = r_instr;
    assign busy_out                = r_busy;
    assign done_out                = r_done;
    assign timeout_error_out       = r_err;
    assign issued_count_out        = r_count;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenario table, hand-written corner
// sequences, and randomized programs checked cycle by cycle against a timeline model.
module tb_instruction_sequencer;
    localparam int          AW    = 8;
    localparam int          TO    = 64;
    localparam int          MAXC  = 2048;
    localparam logic [31:0] NOPW  = 32'h0000_0008;
    localparam logic [31:0] HALTW = 32'h0000_00FF;
    localparam logic [31:0] OPW   = 32'h0000_0005;
    localparam logic [31:0] ADDW  = 32'h0201_0000;
    localparam logic [31:0] SUBW  = 32'h0302_0101;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   plen;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata = 32'h0;
    logic          tcd;
    logic [31:0]   instr;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   cnt;

    logic [31:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    // Timeline model of one run, indexed by cycle after the start edge.
    logic [31:0] m_instr [MAXC];
    bit          m_en    [MAXC];
    bit          m_busy  [MAXC];
    bit          m_done  [MAXC];
    bit          m_wait  [MAXC];
    bit          m_tc    [MAXC];
    bit          m_err   [MAXC];
    int          m_addr  [MAXC];
    int          m_cnt   [MAXC];
    int          m_lat   [256];
    int          m_last;

    typedef struct {
        logic [8:0]       len;
        logic [3:0][31:0] words;
        int               lat;
        int               exp_done;
        int               exp_cnt;
        int               exp_reads;
        logic             exp_err;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    instruction_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock_in                (clk),
        .reset_in                (rst),
        .start_in                (start),
        .program_length_in       (plen),
        .imem_read_enable_out    (ren),
        .imem_read_address_out   (raddr),
        .imem_read_data_in       (rdata),
        .tensor_core_done_in     (tcd),
        .current_instruction_out (instr),
        .busy_out                (busy),
        .done_out                (done),
        .timeout_error_out       (err),
        .issued_count_out        (cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [8:0] len);
        start = 1'b1;
        plen  = len;
        tick();
        start = 1'b0;
    endtask

    // Each instruction costs fetch+issue (2 cycles); an operate adds lat+1 wait cycles, or TO on timeout.
    task automatic build_model(input int len);
        int t;
        int p;
        int d;
        int nt;
        int wlen;
        int cntv;
        bit fin;
        bit tout;
        logic [31:0] w;
        for (int i = 0; i < MAXC; i++) begin
            m_instr[i] = NOPW; m_en[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
            m_wait[i] = 1'b0; m_tc[i] = 1'b0; m_err[i] = 1'b0; m_addr[i] = 0; m_cnt[i] = 0;
        end
        d = 0;
        cntv = 0;
        if (len != 0) begin
            t = 0; p = 0; fin = 1'b0;
            while (!fin) begin
                m_en[t] = 1'b1;
                m_addr[t] = p;
                w = mem[p];
                if (w[7:0] == 8'hFF) begin
                    d = t + 2;
                    fin = 1'b1;
                end else begin
                    if (cntv < 65535) cntv++;
                    m_instr[t+2] = w;
                    for (int c = t + 2; c < MAXC; c++) m_cnt[c] = cntv;
                    tout = 1'b0;
                    if (w[7:0] == 8'h05) begin
                        if (m_lat[p] < TO) begin
                            wlen = m_lat[p] + 1;
                            m_tc[t+2+m_lat[p]] = 1'b1;
                        end else begin
                            wlen = TO;
                            tout = 1'b1;
                        end
                        for (int c = t + 2; c < t + 2 + wlen; c++) m_wait[c] = 1'b1;
                        nt = t + 2 + wlen;
                    end else begin
                        nt = t + 2;
                    end
                    if (tout) begin
                        for (int c = nt; c < MAXC; c++) m_err[c] = 1'b1;
                        d = nt; fin = 1'b1;
                    end else if (p == len - 1) begin
                        d = nt; fin = 1'b1;
                    end else begin
                        p++;
                        t = nt;
                    end
                end
            end
        end
        for (int c = 0; c < d; c++) m_busy[c] = 1'b1;
        m_done[d+1] = 1'b1;
        m_last = d + 1;
    endtask

    task automatic rand_run(input int r);
        int len;
        int s;
        logic [7:0] op;
        len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
        for (int a = 0; a < 16; a++) begin
            s = int'($urandom_range(0, 9));
            if (s == 0) mem[a] = {24'($urandom), 8'hFF};
            else if (s <= 2) mem[a] = {24'($urandom), 8'h05};
            else if (s == 3) mem[a] = NOPW;
            else begin
                op = 8'($urandom_range(0, 254));
                if (op == 8'h05) op = 8'h06;
                mem[a] = {24'($urandom), op};
            end
            s = int'($urandom_range(0, 15));
            m_lat[a] = (s == 0) ? 100 : (s == 1) ? 63 : int'($urandom_range(0, 12));
        end
        build_model(len);
        start_run(9'(len));
        for (int c = 0; c <= m_last; c++) begin
            check($sformatf("r%0d_c%0d_instr", r, c), instr, m_instr[c]);
            check($sformatf("r%0d_c%0d_ren", r, c), 32'(ren), 32'(m_en[c]));
            check($sformatf("r%0d_c%0d_busy", r, c), 32'(busy), 32'(m_busy[c]));
            check($sformatf("r%0d_c%0d_done", r, c), 32'(done), 32'(m_done[c]));
            check($sformatf("r%0d_c%0d_err", r, c), 32'(err), 32'(m_err[c]));
            check($sformatf("r%0d_c%0d_cnt", r, c), 32'(cnt), 32'(m_cnt[c]));
            if (m_en[c]) check($sformatf("r%0d_c%0d_addr", r, c), 32'(raddr), 32'(m_addr[c]));
            tcd = m_tc[c] || (!m_wait[c] && ($urandom_range(0, 3) == 0));
            if (m_busy[c] && ($urandom_range(0, 4) == 0)) begin
                start = 1'b1;
                plen  = 9'($urandom_range(0, 511));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        tcd = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int got;
        int tc_at;
        int reads;
        int maxa;

        tbl[0] = '{len: 9'd3, words: {NOPW, NOPW, SUBW, ADDW}, lat: 0,
                   exp_done: 7, exp_cnt: 3, exp_reads: 3, exp_err: 1'b0};
        tbl[1] = '{len: 9'd2, words: {NOPW, NOPW, ADDW, OPW}, lat: 5,
                   exp_done: 11, exp_cnt: 2, exp_reads: 2, exp_err: 1'b0};
        tbl[2] = '{len: 9'd1, words: {NOPW, NOPW, NOPW, OPW}, lat: 255,
                   exp_done: 67, exp_cnt: 1, exp_reads: 1, exp_err: 1'b1};
        tbl[3] = '{len: 9'd3, words: {NOPW, SUBW, HALTW, ADDW}, lat: 0,
                   exp_done: 5, exp_cnt: 1, exp_reads: 2, exp_err: 1'b0};
        tbl[4] = '{len: 9'd0, words: {ADDW, ADDW, ADDW, ADDW}, lat: 0,
                   exp_done: 1, exp_cnt: 0, exp_reads: 0, exp_err: 1'b0};
        tbl[5] = '{len: 9'd1, words: {NOPW, NOPW, NOPW, OPW}, lat: 0,
                   exp_done: 4, exp_cnt: 1, exp_reads: 1, exp_err: 1'b0};
        tbl[6] = '{len: 9'd1, words: {NOPW, NOPW, NOPW, OPW}, lat: 63,
                   exp_done: 67, exp_cnt: 1, exp_reads: 1, exp_err: 1'b0};
        tbl[7] = '{len: 9'd4, words: {32'hABCD_0008, SUBW, NOPW, ADDW}, lat: 0,
                   exp_done: 9, exp_cnt: 4, exp_reads: 4, exp_err: 1'b0};

        for (int a = 0; a < 256; a++) mem[a] = NOPW;
        rst = 1'b1; start = 1'b0; plen = 9'd0; tcd = 1'b0;
        tick();
        tick();
        check("rst_instr", instr, NOPW);
        check("rst_ren", 32'(ren), 32'd0);
        check("rst_addr", 32'(raddr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int a = 0; a < 4; a++) mem[a] = tbl[i].words[a];
            start_run(tbl[i].len);
            k = 0; got = -1; tc_at = -1; reads = 0;
            while (k < 200 && got < 0) begin
                if (ren) reads++;
                if (done) begin
                    got = k;
                end else begin
                    if (instr[7:0] == 8'h05 && tc_at < 0) tc_at = k + tbl[i].lat;
                    tcd = (k == tc_at);
                    tick();
                    k++;
                end
            end
            tcd = 1'b0;
            check($sformatf("tbl%0d_done_cycle", i), 32'(got), 32'(tbl[i].exp_done));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_reads", i), 32'(reads), 32'(tbl[i].exp_reads));
            tick();
            check($sformatf("tbl%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("tbl%0d_idle_busy", i), 32'(busy), 32'd0);
            check($sformatf("tbl%0d_err_sticky", i), 32'(err), 32'(tbl[i].exp_err));
        end

        // A start held high while busy must not relaunch or relatch the length.
        mem[0] = OPW; mem[1] = ADDW;
        start_run(9'd1);
        start = 1'b1; plen = 9'd5;
        tick();
        tick();
        check("busy_start_busy", 32'(busy), 32'd1);
        check("busy_start_op", instr, OPW);
        tick();
        check("busy_start_nop", instr, NOPW);
        check("busy_start_cnt", 32'(cnt), 32'd1);
        start = 1'b0; tcd = 1'b1;
        tick();
        tcd = 1'b0;
        check("busy_start_finish", 32'(busy), 32'd0);
        check("busy_start_noread", 32'(ren), 32'd0);
        tick();
        check("busy_start_done", 32'(done), 32'd1);
        tick();

        // Reset in the middle of a tensor-core wait aborts without a done pulse.
        start_run(9'd2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_instr", instr, NOPW);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_cnt", 32'(cnt), 32'd0);
        check("midrst_ren", 32'(ren), 32'd0);
        got = 0;
        for (int c = 0; c < 5; c++) begin
            tcd = 1'b1;
            tick();
            if (done || busy) got++;
        end
        tcd = 1'b0;
        check("midrst_quiet", 32'(got), 32'd0);

        // Full-size program: every address once, no wrap.
        for (int a = 0; a < 256; a++) mem[a] = {8'h10, 8'(a), 8'h00, 8'h01};
        start_run(9'd256);
        k = 0; got = -1; reads = 0; maxa = 0;
        while (k < 600 && got < 0) begin
            if (ren) begin
                reads++;
                if (int'(raddr) > maxa) maxa = int'(raddr);
            end
            if (done) got = k;
            else begin
                tick();
                k++;
            end
        end
        check("full_done_cycle", 32'(got), 32'd513);
        check("full_cnt", 32'(cnt), 32'd256);
        check("full_reads", 32'(reads), 32'd256);
        check("full_max_addr", 32'(maxa), 32'd255);
        tick();

        for (int r = 0; r < 40; r++) rand_run(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
